// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches on a credit budget,
// tags them with their pc, and queues returning words for decode.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic          run_q, run_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [31:0]   tag_mem   [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic          grant, resp, push, pop, fifo_empty;
  logic [CW:0]   used;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    fifo_empty = (fifo_cnt_q == '0);
    used       = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
    // run_q holds requests off until the first edge after reset release
    imem_req   = run_q && !redirect && (used < DEPTH_W);
    imem_addr  = pc_q;
    id_valid   = !fifo_empty && !redirect;
    id_instr   = fifo_empty ? '0 : instr_mem[fifo_rd_q];
    id_pc      = fifo_empty ? '0 : pc_mem[fifo_rd_q];
    grant      = imem_req && imem_gnt;
    resp       = imem_rvalid && (in_flight_q != '0);
    push       = resp && !redirect && (drop_q == '0);
    pop        = id_valid && id_ready;
  end

  always_comb begin
    run_d       = 1'b1;
    pc_d        = pc_q;
    drop_d      = drop_q;
    fifo_cnt_d  = fifo_cnt_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_rd_d   = fifo_rd_q;
    in_flight_d = in_flight_q;
    tag_wr_d    = grant ? tag_wr_q + AW'(1) : tag_wr_q;
    tag_rd_d    = resp  ? tag_rd_q + AW'(1) : tag_rd_q;
    case ({grant, resp})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase
    if (redirect) begin
      // everything still outstanding becomes a drop, except a word landing now
      pc_d       = {redirect_pc[31:2], 2'b00};
      drop_d     = resp ? in_flight_q - CW'(1) : in_flight_q;
      fifo_cnt_d = '0;
      fifo_rd_d  = fifo_wr_q;
    end else begin
      if (grant) pc_d = pc_q + 32'd4;
      if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) fifo_wr_d = fifo_wr_q + AW'(1);
      if (pop)  fifo_rd_d = fifo_rd_q + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q       <= 1'b0;
      pc_q        <= RESET_PC;
      in_flight_q <= '0;
      drop_q      <= '0;
      fifo_cnt_q  <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
    end else begin
      run_q       <= run_d;
      pc_q        <= pc_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      fifo_cnt_q  <= fifo_cnt_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr_q] <= pc_q;
    if (push) begin
      instr_mem[fifo_wr_q] <= imem_rdata;
      pc_mem[fifo_wr_q]    <= tag_mem[tag_rd_q];
    end
  end

  a_push_not_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && (fifo_cnt_q == CW'(DEPTH))));
  a_rvalid_expected: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rvalid && (in_flight_q == '0)));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit: a memory responder with a
// latency queue and a scoreboard of expected {pc, instr} deliveries.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_gnt, imem_rvalid, redirect, id_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t       mq[$];
  exp_t        sb[$];
  int unsigned cyc = 0, lat_min = 1, lat_max = 1;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] last_xfer_pc = '0, pc_before;
  int          avail = 0, n_grants = 0, n_xfers = 0, late_resp = 0, mark;
  int          n_checks = 0, n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive memory response, sample at +1, update model, advance.
  task automatic cycle();
    bit resp, live, grant, xfer, exp_req;
    mreq_t m;
    exp_t e;
    resp = (mq.size() != 0) && (cyc >= mq[0].due);
    live = 1'b0;
    imem_rvalid = resp;
    imem_rdata  = resp ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_req = !redirect && ((mq.size() + avail) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, model_pc);
    chk("id_valid", 32'(id_valid), 32'((avail > 0) && !redirect));
    if (id_valid && sb.size() != 0) begin
      chk("id_pc", id_pc, sb[0].pc);
      chk("id_instr", id_instr, sb[0].instr);
    end
    grant = imem_req && imem_gnt;
    xfer  = id_valid && id_ready;
    if (resp) begin
      m = mq.pop_front();
      live = !m.stale && !redirect;
    end
    if (redirect) begin
      model_pc = {redirect_pc[31:2], 2'b00};
      sb.delete();
      avail = 0;
      foreach (mq[i]) mq[i].stale = 1'b1;
    end else begin
      if (xfer && sb.size() != 0) begin
        e = sb.pop_front();
        last_xfer_pc = e.pc;
        n_xfers++;
        if (avail > 0) avail--;
      end
      if (grant) begin
        m.addr = model_pc; m.due = cyc + $urandom_range(lat_min, lat_max); m.stale = 1'b0;
        mq.push_back(m);
        e.pc = model_pc; e.instr = mem_word(model_pc);
        sb.push_back(e);
        n_grants++;
        model_pc = model_pc + 32'd4;
      end
      if (live) avail++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    imem_gnt = 1'b0; id_ready = 1'b1; redirect = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 0 && avail == 0) break;
      cycle();
    end
    chk("drain_done", 32'(mq.size() + avail), 32'd0);
  endtask

  task automatic wait_xfer(input string tag, input logic [31:0] exp_pc);
    mark = n_xfers;
    for (int i = 0; i < 30; i++) begin
      if (n_xfers != mark) break;
      cycle();
    end
    chk({tag, "_seen"}, 32'(n_xfers != mark), 32'd1);
    chk(tag, last_xfer_pc, exp_pc);
  endtask

  initial begin
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_instr", id_instr, 32'd0);
      chk("rst_pc", id_pc, 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
    end
    reset = 1'b1;
    #1 chk("req_before_edge", 32'(imem_req), 32'd0);
    @(posedge clk); @(negedge clk);

    // Decode stalled: two grants fill the buffer, head frozen at pc 0.
    imem_gnt = 1'b1; id_ready = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    chk("stall_grants", 32'(n_grants), 32'd2);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_pc", id_pc, 32'h0);
    chk("stall_instr", id_instr, mem_word(32'h0));
    id_ready = 1'b1;
    mark = n_grants;
    for (int i = 0; i < 10; i++) begin
      if (n_grants != mark) break;
      cycle();
    end
    chk("resume_addr", model_pc, 32'h0000_000C);

    // Streaming with 1-cycle memory.
    for (int i = 0; i < 16; i++) cycle();

    // Two in flight (8, 12), then redirect to 0x100.
    drain();
    lat_min = 4; lat_max = 4; imem_gnt = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h8; cycle(); redirect = 1'b0;
    cycle(); cycle();
    chk("two_in_flight", 32'(mq.size()), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h100; cycle(); redirect = 1'b0;
    chk("redir_addr", imem_addr, 32'h100);
    wait_xfer("redir_first_pc", 32'h100);

    // Unaligned redirect target, then redirect colliding with a response.
    drain();
    lat_min = 1; lat_max = 1; imem_gnt = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h203; cycle(); redirect = 1'b0;
    chk("align_addr", imem_addr, 32'h200);
    cycle();
    redirect = 1'b1; redirect_pc = 32'h300; cycle(); redirect = 1'b0;
    wait_xfer("collide_next_pc", 32'h300);

    // Grant withheld: address must hold.
    drain();
    imem_gnt = 1'b0; id_ready = 1'b1;
    pc_before = model_pc;
    for (int i = 0; i < 3; i++) cycle();
    chk("gnt_low_req", 32'(imem_req), 32'd1);
    chk("gnt_low_addr", imem_addr, pc_before);

    // Address wrap at top of memory.
    imem_gnt = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; cycle(); redirect = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // Random latency, grant, ready and redirect.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 300; i++) begin
      imem_gnt    = ($urandom_range(0, 3) != 0);
      id_ready    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 1023));
      cycle();
    end
    redirect = 1'b0;
    drain();

    // Asynchronous reset with two requests outstanding.
    lat_min = 4; lat_max = 4; imem_gnt = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (mq.size() == 2) break;
      cycle();
    end
    chk("pre_reset_in_flight", 32'(mq.size()), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_valid", 32'(id_valid), 32'd0);
    chk("async_instr", id_instr, 32'd0);
    chk("async_pc", id_pc, 32'd0);
    chk("async_addr", imem_addr, RESET_PC);
    // Old requests die with the reset; memory never returns them.
    late_resp += mq.size();
    mq.delete(); sb.delete(); avail = 0; model_pc = RESET_PC; imem_rvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1 chk("post_rst_req_low", 32'(imem_req), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC);
    lat_min = 1; lat_max = 3;
    wait_xfer("post_rst_first_pc", RESET_PC);
    for (int i = 0; i < 20; i++) cycle();
    drain();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_valid", 32'(id_valid), 32'd0);
    $display("discarded %0d pre-reset responses", late_resp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
